// File: rtl/a_coef_pkg.sv
// rtl/a_coef_pkg.sv - shared sizes, FSM state type and helpers for the coefficient bank
package a_coef_pkg;

    localparam int COEF_W = 7;
    localparam int ROWS   = 8;
    localparam int COLS   = 4;
    localparam int WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Number of packed words already written; range 0..16 needs 5 bits.
    function automatic logic [4:0] popcnt16(input logic [WORDS-1:0] m);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < WORDS; i++) begin
            cnt = cnt + {4'd0, m[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/a_coef_regfile.sv
// rtl/a_coef_regfile.sv - coefficient storage: paired-row write port, registered read port
//
// Ports:
//   clk, rst                     clock, async active-high reset (clears storage and rd_data)
//   wr_en                        write both entries this cycle
//   wr_row_even, wr_col          even row index (odd row is the next one) and column
//   wr_even, wr_odd              coefficient for the even / odd row
//   rd_en, rd_row, rd_col        read request; rd_data updates on the next edge, holds otherwise
//   rd_data                      registered read data
module a_coef_regfile #(
    parameter int COEF_W = 7,
    parameter int ROWS   = 8,
    parameter int COLS   = 4,
    parameter int RW     = $clog2(ROWS),
    parameter int CW     = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_row_even,
    input  logic [CW-1:0]     wr_col,
    input  logic [COEF_W-1:0] wr_even,
    input  logic [COEF_W-1:0] wr_odd,
    input  logic              rd_en,
    input  logic [RW-1:0]     rd_row,
    input  logic [CW-1:0]     rd_col,
    output logic [COEF_W-1:0] rd_data
);

    logic [COEF_W-1:0] mem [ROWS][COLS];
    logic [RW-1:0]     wr_row_odd;

    assign wr_row_odd = {wr_row_even[RW-1:1], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_row_even][wr_col] <= wr_even;
            mem[wr_row_odd][wr_col]  <= wr_odd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_row][rd_col];
        end
    end

endmodule

// File: rtl/a_coef_bank.sv
// rtl/a_coef_bank.sv - coefficient bank: tracked packed-word load, then latency-1 reads
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_valid/wr_addr/wr_data packed write: col=wr_addr[3:2], k=wr_addr[1:0],
//                            wr_data upper half -> row 2k, lower half -> row 2k+1
//   load_done                loader finished (level), evaluated only while loading
//   reload                   one-cycle pulse: back to IDLE, mask and word_cnt cleared
//   rd_req/rd_row/rd_col     read request, honoured only in READY
//   rd_valid/rd_data         read response one cycle after the request
//   bank_ready, load_err     registered status: in READY / in ERROR
//   word_cnt                 number of distinct words written in the current load
//   checksum                 only with A_COEF_CHECKSUM_EN: 16-bit sum of accepted wr_data
module a_coef_bank #(
    parameter int COEF_W = a_coef_pkg::COEF_W,
    parameter int ROWS   = a_coef_pkg::ROWS,
    parameter int COLS   = a_coef_pkg::COLS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [3:0]          wr_addr,
    input  logic [2*COEF_W-1:0] wr_data,
    input  logic                load_done,
    input  logic                reload,
    input  logic                rd_req,
    input  logic [2:0]          rd_row,
    input  logic [1:0]          rd_col,
    output logic                rd_valid,
    output logic [COEF_W-1:0]   rd_data,
    output logic                bank_ready,
    output logic                load_err,
    output logic [4:0]          word_cnt
`ifdef A_COEF_CHECKSUM_EN
    ,
    output logic [15:0]         checksum
`endif
);

    import a_coef_pkg::*;

    state_t           state, state_next;
    logic [WORDS-1:0] mask, mask_next;
    logic             accept_wr;
    logic             rd_en;

    // Writes count only while a load can still be in progress; reload drops them.
    assign accept_wr = wr_valid && !reload && (state == IDLE || state == LOAD);
    assign mask_next = accept_wr ? (mask | (WORDS'(1) << wr_addr)) : mask;
    assign rd_en     = rd_req && !reload && (state == READY);

    // The full-mask check uses mask_next so a write landing with load_done counts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_valid) state_next = LOAD;
            LOAD:    if (load_done) state_next = (&mask_next) ? READY : ERROR;
            default: ;
        endcase
        if (reload) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mask       <= '0;
            word_cnt   <= '0;
            bank_ready <= 1'b0;
            load_err   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            // Status flags are decoded from the next state so they track state exactly.
            bank_ready <= (state_next == READY);
            load_err   <= (state_next == ERROR);
            rd_valid   <= rd_en;
            if (reload) begin
                mask     <= '0;
                word_cnt <= '0;
            end else begin
                mask     <= mask_next;
                word_cnt <= popcnt16(mask_next);
            end
        end
    end

`ifdef A_COEF_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (reload) begin
            checksum <= '0;
        end else if (accept_wr) begin
            checksum <= checksum + 16'(wr_data);
        end
    end
`endif

    a_coef_regfile #(
        .COEF_W (COEF_W),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (accept_wr),
        .wr_row_even ({wr_addr[1:0], 1'b0}),
        .wr_col      (wr_addr[3:2]),
        .wr_even     (wr_data[2*COEF_W-1:COEF_W]),
        .wr_odd      (wr_data[COEF_W-1:0]),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data)
    );

endmodule

// File: tb/tb_a_coef_bank.sv
// tb/tb_a_coef_bank.sv - self-checking bench for a_coef_bank
module tb_a_coef_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [13:0] wr_data = '0;
    logic        load_done = 1'b0;
    logic        reload = 1'b0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_row = '0;
    logic [1:0]  rd_col = '0;
    logic        rd_valid;
    logic [6:0]  rd_data;
    logic        bank_ready;
    logic        load_err;
    logic [4:0]  word_cnt;
`ifdef A_COEF_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    a_coef_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .reload     (reload),
        .rd_req     (rd_req),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .bank_ready (bank_ready),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
`ifdef A_COEF_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    typedef struct {
        logic [2:0] row;
        logic [1:0] col;
        logic [6:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] std_word(input int a);
        logic [6:0] hi, lo;
        hi = 7'(a + 1);
        lo = 7'(a + 2);
        return {hi, lo};
    endfunction

    task automatic do_wr(input logic [3:0] a, input logic [13:0] d, input logic ld);
        wr_valid  = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        load_done = ld;
        tick();
        wr_valid  = 1'b0;
        load_done = 1'b0;
    endtask

    task automatic do_rd(input string name, input logic [2:0] r, input logic [1:0] c,
                         input logic [6:0] exp);
        rd_req = 1'b1;
        rd_row = r;
        rd_col = c;
        tick();
        rd_req = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic pulse_load_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    initial begin
        // coef[row][col] for the standard load: addr = col*4 + row/2, value = addr+1 (+1 if odd row)
        vecs[0] = '{3'd0, 2'd0, 7'd1};
        vecs[1] = '{3'd1, 2'd0, 7'd2};
        vecs[2] = '{3'd7, 2'd0, 7'd5};
        vecs[3] = '{3'd0, 2'd1, 7'd5};
        vecs[4] = '{3'd2, 2'd1, 7'd6};
        vecs[5] = '{3'd5, 2'd2, 7'd12};
        vecs[6] = '{3'd3, 2'd2, 7'd11};
        vecs[7] = '{3'd6, 2'd3, 7'd16};
        vecs[8] = '{3'd7, 2'd3, 7'd17};

        #12;
        chk("rst_bank_ready", 32'(bank_ready), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // load_done alone and rd_req in IDLE do nothing
        load_done = 1'b1;
        rd_req    = 1'b1;
        tick();
        load_done = 1'b0;
        rd_req    = 1'b0;
        chk("idle_ld_ready", 32'(bank_ready), 32'd0);
        chk("idle_ld_err", 32'(load_err), 32'd0);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);

        // full in-order load, with a read attempt during LOAD
        for (int a = 0; a < 16; a++) begin
            rd_req = (a == 5);
            do_wr(4'(a), std_word(a), 1'b0);
            if (a == 5) chk("load_rd_valid", 32'(rd_valid), 32'd0);
        end
        rd_req = 1'b0;
        chk("full_word_cnt", 32'(word_cnt), 32'd16);
        chk("full_pre_ready", 32'(bank_ready), 32'd0);
        pulse_load_done();
        chk("full_ready", 32'(bank_ready), 32'd1);
        chk("full_err", 32'(load_err), 32'd0);

        // back-to-back table reads
        for (int i = 0; i < 9; i++) begin
            rd_req = 1'b1;
            rd_row = vecs[i].row;
            rd_col = vecs[i].col;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(vecs[i].exp));
        end
        rd_req = 1'b0;
        tick();
        chk("hold_valid", 32'(rd_valid), 32'd0);
        chk("hold_data", 32'(rd_data), 32'd17);

        // writes ignored in READY
        do_wr(4'd0, 14'h3FFF, 1'b0);
        chk("ready_wr_cnt", 32'(word_cnt), 32'd16);
        do_rd("ready_wr_rd", 3'd0, 2'd0, 7'd1);

        // reload wins over a read in READY
        reload = 1'b1;
        rd_req = 1'b1;
        tick();
        reload = 1'b0;
        rd_req = 1'b0;
        chk("reload_rd_valid", 32'(rd_valid), 32'd0);
        chk("reload_ready", 32'(bank_ready), 32'd0);
        chk("reload_cnt", 32'(word_cnt), 32'd0);

        // incomplete load -> ERROR
        for (int a = 0; a < 16; a++) begin
            if (a != 9) do_wr(4'(a), std_word(a), 1'b0);
        end
        chk("part_cnt", 32'(word_cnt), 32'd15);
        pulse_load_done();
        chk("part_err", 32'(load_err), 32'd1);
        chk("part_ready", 32'(bank_ready), 32'd0);
        do_wr(4'd9, std_word(9), 1'b0);
        chk("err_wr_cnt", 32'(word_cnt), 32'd15);
        pulse_reload();
        chk("err_reload_err", 32'(load_err), 32'd0);
        chk("err_reload_cnt", 32'(word_cnt), 32'd0);

        // duplicate address overwrite
        do_wr(4'd3, 14'h0081, 1'b0);
        chk("dup_cnt1", 32'(word_cnt), 32'd1);
        do_wr(4'd3, 14'h0102, 1'b0);
        chk("dup_cnt2", 32'(word_cnt), 32'd1);
        for (int a = 0; a < 16; a++) begin
            if (a != 3) do_wr(4'(a), std_word(a), 1'b0);
        end
        chk("dup_cnt16", 32'(word_cnt), 32'd16);
        pulse_load_done();
        chk("dup_ready", 32'(bank_ready), 32'd1);
        do_rd("dup_r6", 3'd6, 2'd0, 7'd2);
        do_rd("dup_r7", 3'd7, 2'd0, 7'd2);

        // reload with a simultaneous write drops the write
        reload   = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 4'd1;
        wr_data  = 14'h0055;
        tick();
        reload   = 1'b0;
        wr_valid = 1'b0;
        chk("reload_wr_cnt", 32'(word_cnt), 32'd0);

        // last write coincides with load_done -> READY
        for (int a = 0; a < 15; a++) do_wr(4'(a), 14'h3FFF, 1'b0);
        do_wr(4'd15, 14'h3FFF, 1'b1);
        chk("same_cyc_ready", 32'(bank_ready), 32'd1);
        chk("same_cyc_err", 32'(load_err), 32'd0);
        chk("same_cyc_cnt", 32'(word_cnt), 32'd16);
`ifdef A_COEF_CHECKSUM_EN
        chk("checksum_3fff", 32'(checksum), 32'h0000FFF0);
`endif
        do_rd("ones_rd", 3'd4, 2'd2, 7'h7F);

        // reset asserted mid-load
        pulse_reload();
        for (int a = 0; a < 3; a++) do_wr(4'(a), std_word(a), 1'b0);
        wr_valid = 1'b1;
        wr_addr  = 4'd4;
        wr_data  = std_word(4);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 32'(word_cnt), 32'd0);
        chk("midrst_ready", 32'(bank_ready), 32'd0);
        chk("midrst_err", 32'(load_err), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
`ifdef A_COEF_CHECKSUM_EN
        chk("midrst_checksum", 32'(checksum), 32'd0);
`endif
        tick();
        chk("midrst_hold_cnt", 32'(word_cnt), 32'd0);
        wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulse_load_done();
        chk("post_rst_ready", 32'(bank_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/a_coef_bank.md
A_COEF_BANK -- requirements
Module: a_coef_bank

Interface
REQ-001 SHALL have parameter COEF_W, default 7, giving the width of one coefficient.
REQ-002 SHALL have parameter ROWS, default 8, giving the number of coefficient-matrix rows.
REQ-003 SHALL have parameter COLS, default 4, giving the number of coefficient-matrix columns.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit, marking wr_addr/wr_data valid this cycle.
REQ-007 SHALL have port wr_addr, input, 4 bits, the packed-word index 0-15.
REQ-008 SHALL have port wr_data, input, 2*COEF_W bits, {coef_even[13:7], coef_odd[6:0]}.
REQ-009 SHALL have port load_done, input, 1 bit, the upstream loader finished flag (level).
REQ-010 SHALL have port reload, input, 1 bit, a one-cycle pulse that discards the current load.
REQ-011 SHALL have port rd_req, input, 1 bit, the read request.
REQ-012 SHALL have port rd_row, input, 3 bits, the 0-based row; rd_col, input, 2 bits, the 0-based column.
REQ-013 SHALL have port rd_valid, output, 1 bit, and rd_data, output, COEF_W bits, the read response.
REQ-014 SHALL have ports bank_ready (1 bit), load_err (1 bit) and word_cnt (5 bits) as outputs, giving status.

Function
REQ-015 SHALL map a write to col=wr_addr[3:2], k=wr_addr[1:0]; wr_data[13:7] goes to row 2k and wr_data[6:0] to row 2k+1.
REQ-016 SHALL keep a 16-bit written mask; word_cnt SHALL equal the number of set mask bits (0-16).
REQ-017 SHALL use FSM states IDLE, LOAD, READY, ERROR; reset state is IDLE.
REQ-018 IDLE: wr_valid -> LOAD with that write accepted; load_done alone SHALL NOT leave IDLE.
REQ-019 LOAD: each wr_valid writes storage and sets its mask bit; a duplicate address overwrites data and leaves word_cnt unchanged.
REQ-020 LOAD: when load_done=1 and the mask is full -> READY; when load_done=1 and the mask is not full -> ERROR.
REQ-021 When wr_valid and load_done occur in the same cycle, the write SHALL be applied before the full-mask check.
REQ-022 READY/ERROR: wr_valid SHALL be ignored (no storage, mask or word_cnt change).
REQ-023 bank_ready=1 exactly in READY; load_err=1 exactly in ERROR; both are registered outputs.
REQ-024 A read with rd_req=1 in READY SHALL give rd_valid=1 and rd_data=coef[rd_row][rd_col] on the next cycle (latency 1); reads accepted every cycle.
REQ-025 rd_req outside READY SHALL give rd_valid=0 next cycle; rd_data SHALL hold its last value while rd_valid=0.
REQ-026 reload in any state SHALL go to IDLE next cycle and clear mask and word_cnt; storage contents are retained but not readable.
REQ-027 reload SHALL take priority over a simultaneous wr_valid, load_done or rd_req (the write is dropped, rd_valid=0).

Reset
REQ-028 On rst: state=IDLE, mask=0, word_cnt=0, bank_ready=0, load_err=0, rd_valid=0, rd_data=0, storage all zero.
REQ-029 Reset asserted mid-load or mid-read SHALL abort immediately with no further writes or rd_valid.

Configuration
REQ-030 With macro A_COEF_CHECKSUM_EN defined, SHALL add a 16-bit output checksum = modulo-2^16 sum of every accepted wr_data (zero-extended), including duplicates.
REQ-031 checksum SHALL reset to 0 on rst and clear on reload.
REQ-032 Without A_COEF_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 SHALL have a shared package a_coef_pkg holding COEF_W, ROWS, COLS, WORDS=16 and the FSM state typedef.
REQ-034 SHALL place storage in sub-module a_coef_regfile: ROWS*COLS x COEF_W entries, a dual-entry write port and a registered single read port.

Verification
REQ-035 Write addr 0-15 in order with data {addr+1, addr+2} (7-bit fields), then raise load_done -> bank_ready=1 the next cycle, word_cnt=16, and a read of row 0/col 0 returns 1 one cycle later.
REQ-036 Write 15 words (skip addr 9), then load_done -> load_err=1, bank_ready=0; pulse reload -> IDLE, word_cnt=0.
REQ-037 Write addr 3 twice (0x0081 then 0x0102) plus the other 14 words -> word_cnt=16, and rows 6/7 of col 0 read 2 and 2.
REQ-038 Write the last word in the same cycle load_done rises -> READY (not ERROR).
REQ-039 Assert rd_req in LOAD -> rd_valid=0; do back-to-back reads in READY -> rd_valid=1 every cycle with the correct data.
REQ-040 With A_COEF_CHECKSUM_EN, 16 writes of 0x3FFF -> checksum=0xFFF0; assert rst mid-load -> all outputs zero.
